// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: mode encodings and
// stage-count helpers used when sizing the pipeline.
package adder_pkg;

    localparam logic ADDSUB_ADD = 1'b0;
    localparam logic ADDSUB_SUB = 1'b1;

    function automatic int stage_count(input int n, input int chunk);
        return n / chunk;
    endfunction

    function automatic bit chunk_fits(input int n, input int chunk);
        return (chunk > 0) && (n >= chunk) && (n % chunk == 0);
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline stage: ripple-adds chunk K, then registers the partial result,
// the chunk carry and the operand chunks still to be added, with valid/ready flow control.
module addsub_stage #(
    parameter int N     = 8,
    parameter int CHUNK = 4,
    parameter int K     = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic         sub_i,
    input  logic         carry_i,
    input  logic         ready_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] res_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic         sub_o,
    output logic         carry_o,
    output logic         msb_cin_o,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    output logic [N-1:0] res_o
);

    localparam int LO = K * CHUNK;
    localparam bit LAST = (K == N / CHUNK - 1);
    // Result chunks 0..K travel forward; only operand chunks above K are still needed.
    localparam logic [N-1:0] KEEP_RES = {N{1'b1}} >> (N - LO - CHUNK);
    localparam logic [N-1:0] KEEP_OPS = ~KEEP_RES;

    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] sum;
    logic [N-1:0]     res_d;
    logic             load;

    logic             valid_q, sub_q, carry_q, msb_q;
    logic [N-1:0]     a_q, b_q, res_q;

    assign c[0] = carry_i;

    for (genvar j = 0; j < CHUNK; j++) begin : g_bit
        full_adder u_fa (
            .a_i    (a_i[LO+j]),
            .b_i    (b_i[LO+j]),
            .c_i    (c[j]),
            .sum_o  (sum[j]),
            .carry_o(c[j+1])
        );
    end

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        res_d             = res_i;
        res_d[LO +: CHUNK] = sum;
    end

    assign ready_o = !valid_q || ready_i;
    assign load    = ready_o && valid_i;

    // NOTE: sequential state uses non-blocking assignments so all stages update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (ready_o) begin
            valid_q <= valid_i;
        end
    end

    // NOTE: payload needs no reset; only the last stage clears because it drives the outputs.
    always_ff @(posedge clk) begin
        if (LAST && rst) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            msb_q   <= 1'b0;
        end else if (load) begin
            sub_q   <= sub_i;
            carry_q <= c[CHUNK];
            msb_q   <= c[CHUNK-1];
            res_q   <= res_d & KEEP_RES;
            a_q     <= a_i & KEEP_OPS;
            b_q     <= b_i & KEEP_OPS;
        end
    end

    assign valid_o   = valid_q;
    assign sub_o     = sub_q;
    assign carry_o   = carry_q;
    assign msb_cin_o = msb_q;
    assign a_o       = a_q;
    assign b_o       = b_q;
    assign res_o     = res_q;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder built from two half adder cells.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);

    logic s0, c0, c1;

    half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .sum_o(s0),    .carry_o(c0));
    half_adder u_ha1 (.a_i(s0),  .b_i(c_i), .sum_o(sum_o), .carry_o(c1));

    assign carry_o = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder cell.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule

// File: rtl/pipelined_addsub.sv
// N-bit add/subtract unit split into CHUNK-bit ripple stages, one per cycle,
// with valid/ready handshakes on input and output and per-stage bubble collapse.
module pipelined_addsub
    import adder_pkg::*;
#(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] number1,
    input  logic [N-1:0] number2,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry_out,
    output logic         overflow
);

    localparam int STAGES = stage_count(N, CHUNK);

    if (!chunk_fits(N, CHUNK)) begin : g_bad_cfg
        $error("pipelined_addsub: N must be a positive multiple of CHUNK");
    end

    logic [STAGES:0]   v_s, rdy_s, sub_s, c_s;
    logic [STAGES-1:0] msb_s;
    logic [N-1:0]      a_s   [STAGES+1];
    logic [N-1:0]      b_s   [STAGES+1];
    logic [N-1:0]      res_s [STAGES+1];

    // Subtraction is A + ~B + 1: invert B here and feed the +1 as the chunk-0 carry.
    assign v_s[0]   = in_valid;
    assign sub_s[0] = sub;
    assign c_s[0]   = (sub == ADDSUB_SUB);
    assign a_s[0]   = number1;
    assign b_s[0]   = (sub == ADDSUB_SUB) ? ~number2 : number2;
    assign res_s[0] = '0;

    assign rdy_s[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_stage #(.N(N), .CHUNK(CHUNK), .K(k)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .valid_i  (v_s[k]),
            .sub_i    (sub_s[k]),
            .carry_i  (c_s[k]),
            .ready_i  (rdy_s[k+1]),
            .a_i      (a_s[k]),
            .b_i      (b_s[k]),
            .res_i    (res_s[k]),
            .ready_o  (rdy_s[k]),
            .valid_o  (v_s[k+1]),
            .sub_o    (sub_s[k+1]),
            .carry_o  (c_s[k+1]),
            .msb_cin_o(msb_s[k]),
            .a_o      (a_s[k+1]),
            .b_o      (b_s[k+1]),
            .res_o    (res_s[k+1])
        );
    end

    assign in_ready  = rdy_s[0] && !rst;
    assign out_valid = v_s[STAGES];
    assign result    = res_s[STAGES];
    assign carry_out = c_s[STAGES];
    assign overflow  = msb_s[STAGES-1] ^ c_s[STAGES];

    // Operands and mode are fully consumed by the last stage.
    logic unused_tail;
    assign unused_tail = ^{a_s[STAGES], b_s[STAGES], sub_s[STAGES], msb_s};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed corner cases, random
// back-to-back traffic with backpressure against an arithmetic model, bubble and reset.
module tb_pipelined_addsub;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
    logic [7:0] number1, number2, result;

    logic        w_in_valid, w_in_ready, w_sub, w_out_valid, w_out_ready, w_carry_out, w_overflow;
    logic [31:0] w_number1, w_number2, w_result;

    always #5 clk = ~clk;

    pipelined_addsub #(.N(8), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .number1(number1), .number2(number2), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry_out(carry_out), .overflow(overflow)
    );

    pipelined_addsub #(.N(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .number1(w_number1), .number2(w_number2), .sub(w_sub),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
        .carry_out(w_carry_out), .overflow(w_overflow)
    );

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       o;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   n_out    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int   ua, ub, sa, sb, full, sr;
        exp_t e;
        ua   = a;
        ub   = b;
        sa   = $signed(a);
        sb   = $signed(b);
        full = s ? (ua - ub + 256) : (ua + ub);
        sr   = s ? (sa - sb) : (sa + sb);
        e.res = full[7:0];
        e.c   = full[8];
        e.o   = (sr > 127) || (sr < -128);
        return e;
    endfunction

    // Observe transfers for the current cycle, then advance one clock.
    task automatic tick();
        exp_t e;
        #1;
        if (in_valid && in_ready) exp_q.push_back(model(number1, number2, sub));
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("model_result", result, e.res);
                check("model_carry", carry_out, e.c);
                check("model_ovf", overflow, e.o);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic s, input logic [7:0] er, input logic ec, input logic eo);
        int lat;
        out_ready = 1'b1;
        number1   = a;
        number2   = b;
        sub       = s;
        in_valid  = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_result"}, result, er);
        check({tag, "_carry"}, carry_out, ec);
        check({tag, "_ovf"}, overflow, eo);
        tick();
    endtask

    task automatic directed32(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic s, input logic [31:0] er, input logic ec, input logic eo);
        int lat;
        w_number1  = a;
        w_number2  = b;
        w_sub      = s;
        w_in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, w_in_ready, 1'b1);
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        lat = 1;
        while (!w_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_result"}, w_result, er);
        check({tag, "_carry"}, w_carry_out, ec);
        check({tag, "_ovf"}, w_overflow, eo);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   pat[4] = '{1, 0, 0, 1};
        int   accepted, cyc, held, out_base;
        logic prev_stall;
        logic [7:0] prev_res;
        logic prev_c, prev_o;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; number1 = '0; number2 = '0; sub = 1'b0;
        w_in_valid = 1'b0; w_out_ready = 1'b1; w_number1 = '0; w_number2 = '0; w_sub = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 8'h00);
        check("rst_carry", carry_out, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_out_valid32", w_out_valid, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed corner cases
        directed("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
        directed("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Random back-to-back with out_ready pattern 1,0,0,1
        accepted = 0; cyc = 0; prev_stall = 1'b0;
        prev_res = '0; prev_c = 1'b0; prev_o = 1'b0;
        out_base = n_out;
        number1 = 8'($urandom); number2 = 8'($urandom); sub = 1'($urandom);
        while ((accepted < 32 || exp_q.size() > 0) && cyc < 600) begin
            out_ready = pat[cyc % 4][0];
            in_valid  = (accepted < 32);
            #1;
            held = exp_q.size();
            check("in_ready_rule", in_ready, !(held == 2 && !out_ready));
            if (prev_stall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_result", result, prev_res);
                check("hold_carry", carry_out, prev_c);
                check("hold_ovf", overflow, prev_o);
            end
            prev_stall = out_valid && !out_ready;
            prev_res = result; prev_c = carry_out; prev_o = overflow;
            if (in_valid && in_ready) begin
                accepted++;
                tick();
                number1 = 8'($urandom); number2 = 8'($urandom); sub = 1'($urandom);
            end else begin
                tick();
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("random_received", n_out - out_base, 32);
        check("random_queue_empty", exp_q.size(), 0);

        // Bubble collapse: stage 1 stalled, stage 0 empty
        out_ready = 1'b0;
        number1 = 8'($urandom); number2 = 8'($urandom); sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("bubble_out_valid", out_valid, 1'b1);
        number1 = 8'($urandom); number2 = 8'($urandom); sub = 1'b1;
        in_valid = 1'b1;
        #1;
        check("bubble_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        check("full_in_ready", in_ready, 1'b0);
        check("full_held", exp_q.size(), 2);
        out_ready = 1'b1;
        repeat (4) tick();
        check("bubble_queue_empty", exp_q.size(), 0);

        // Reset mid-operation drops in-flight transactions
        out_ready = 1'b0;
        number1 = 8'($urandom); number2 = 8'($urandom); sub = 1'b0;
        in_valid = 1'b1;
        tick();
        number1 = 8'($urandom);
        tick();
        in_valid = 1'b0;
        check("pre_rst_held", exp_q.size(), 2);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_result", result, 8'h00);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_idle", out_valid, 1'b0);
        end
        directed("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Wider configuration: N=32, CHUNK=8
        directed32("w_add_ffffffff_1", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
        directed32("w_sub_80000000_1", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
